// File: rtl/simple_tx_mcdma_channel_scheduler.sv
// Packet-granular round-robin scheduler for the TX multichannel DMA egress.
// Holds each grant until the TLAST beat and flags long stalls mid-packet.
module simple_tx_mcdma_channel_scheduler #(
  parameter int NUM_CH      = 4,
  parameter int DATA_W      = 32,
  parameter int CH_W        = 2,
  parameter int STALL_LIMIT = 1024,
  parameter int CNT_W       = 16
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [NUM_CH-1:0]        ch_enable,
  input  logic [NUM_CH-1:0]        s_axis_tvalid,
  input  logic [NUM_CH*DATA_W-1:0] s_axis_tdata,
  input  logic [NUM_CH-1:0]        s_axis_tlast,
  output logic [NUM_CH-1:0]        s_axis_tready,
  output logic                     m_axis_tvalid,
  output logic [DATA_W-1:0]        m_axis_tdata,
  output logic                     m_axis_tlast,
  output logic [CH_W-1:0]          m_axis_tdest,
  input  logic                     m_axis_tready,
  output logic                     busy,
  output logic                     stall_flag
);

  typedef enum logic {
    IDLE,
    XFER
  } state_t;

  localparam logic [CNT_W-1:0] LIM = CNT_W'(STALL_LIMIT);
  localparam logic [CH_W-1:0] LAST_CH = CH_W'(NUM_CH - 1);

  state_t r_state;
  state_t w_state_nxt;

  logic [CH_W-1:0]   r_grant;
  logic [CH_W-1:0]   r_last_grant;
  logic [CH_W-1:0]   w_pick;
  logic [NUM_CH-1:0] w_req;
  logic [CNT_W-1:0]  r_stall_cnt;
  logic [CNT_W-1:0]  w_stall_nxt;
  logic              r_stall_flag;
  logic              w_xfer;
  logic              w_beat;
  logic              w_done;

  // First requester after the previous winner, wrapping modulo NUM_CH.
  function automatic logic [CH_W-1:0] f_rr_pick(
    input logic [NUM_CH-1:0] req,
    input logic [CH_W-1:0]   last
  );
    logic [CH_W-1:0] pick;
    logic [CH_W-1:0] k;
    logic            found;
    int              idx;
    pick  = '0;
    found = 1'b0;
    for (int i = 1; i <= NUM_CH; i++) begin
      idx = (int'(last) + i) % NUM_CH;
      k   = CH_W'(idx);
      if (!found && req[k]) begin
        pick  = k;
        found = 1'b1;
      end
    end
    return pick;
  endfunction

  assign w_req  = s_axis_tvalid & ch_enable;
  assign w_pick = f_rr_pick(w_req, r_last_grant);
  assign w_xfer = (r_state == XFER);

  always_comb begin
    s_axis_tready = '0;
    m_axis_tvalid = 1'b0;
    m_axis_tdata  = '0;
    m_axis_tlast  = 1'b0;
    if (w_xfer) begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (r_grant == CH_W'(i)) begin
          m_axis_tvalid    = s_axis_tvalid[i];
          m_axis_tdata     = s_axis_tdata[i*DATA_W +: DATA_W];
          m_axis_tlast     = s_axis_tlast[i];
          s_axis_tready[i] = m_axis_tready;
        end
      end
    end
  end

  assign m_axis_tdest = w_xfer ? r_grant : '0;
  assign busy         = w_xfer;
  assign stall_flag   = r_stall_flag;

  assign w_beat = m_axis_tvalid & m_axis_tready;
  assign w_done = w_beat & m_axis_tlast;

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE: if (|w_req) w_state_nxt = XFER;
      XFER: if (w_done) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    w_stall_nxt = r_stall_cnt;
    if (!w_xfer || w_beat) begin
      w_stall_nxt = '0;
    end else if (r_stall_cnt != LIM) begin
      w_stall_nxt = r_stall_cnt + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_grant      <= '0;
      r_last_grant <= LAST_CH;
      r_stall_cnt  <= '0;
      r_stall_flag <= 1'b0;
    end else begin
      if (!w_xfer && (|w_req)) begin
        r_grant <= w_pick;
      end
      if (w_done) begin
        r_last_grant <= r_grant;
      end
      r_stall_cnt  <= w_stall_nxt;
      r_stall_flag <= (w_stall_nxt == LIM);
    end
  end

endmodule

// File: tb/tb_simple_tx_mcdma_channel_scheduler.sv
// Directed bench for the TX MCDMA channel scheduler.
// Per-channel sources replay numbered packets; checks are hand-computed tables.
module tb_simple_tx_mcdma_channel_scheduler;

  logic         clock = 1'b0;
  logic         reset;
  logic [3:0]   ch_enable;
  logic [3:0]   s_axis_tvalid;
  logic [127:0] s_axis_tdata;
  logic [3:0]   s_axis_tlast;
  logic [3:0]   s_axis_tready;
  logic         m_axis_tvalid;
  logic [31:0]  m_axis_tdata;
  logic         m_axis_tlast;
  logic [1:0]   m_axis_tdest;
  logic         m_axis_tready;
  logic         busy;
  logic         stall_flag;

  int vectors = 0;
  int miscompares = 0;
  int nbeats = 0;

  logic [3:0] src_on;
  logic [3:0] fire;
  int src_len [4];
  int src_beat [4];
  int src_pkt [4];

  int t1_ch [14] = '{0, 0, -1, 1, 1, -1, 2, 2, -1, 3, 3, -1, 0, 0};
  logic [7:0] t1_bt [14] = '{8'h00, 8'h01, 8'h00, 8'h00, 8'h01, 8'h00,
    8'h00, 8'h01, 8'h00, 8'h00, 8'h01, 8'h00, 8'h10, 8'h11};
  int t2_ch [5] = '{2, 2, -1, 2, 2};
  logic [7:0] t2_bt [5] = '{8'h00, 8'h01, 8'h00, 8'h10, 8'h11};
  int t3_ch [8] = '{1, 1, 1, -1, 2, 2, -1, 2};
  logic [7:0] t3_bt [8] = '{8'h01, 8'h02, 8'h03, 8'h00, 8'h00, 8'h01,
    8'h00, 8'h10};
  logic t3_last [8] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
  int t6_ch [9] = '{0, 0, -1, 1, -1, 0, -1, 1, -1};
  logic [7:0] t6_bt [9] = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h10,
    8'h00, 8'h10, 8'h00};

  simple_tx_mcdma_channel_scheduler #(
    .NUM_CH(4),
    .DATA_W(32),
    .CH_W(2),
    .STALL_LIMIT(8),
    .CNT_W(16)
  ) dut (
    .clock(clock),
    .reset(reset),
    .ch_enable(ch_enable),
    .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tdata(s_axis_tdata),
    .s_axis_tlast(s_axis_tlast),
    .s_axis_tready(s_axis_tready),
    .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tdata(m_axis_tdata),
    .m_axis_tlast(m_axis_tlast),
    .m_axis_tdest(m_axis_tdest),
    .m_axis_tready(m_axis_tready),
    .busy(busy),
    .stall_flag(stall_flag)
  );

  always #5 clock = ~clock;

  function automatic logic [31:0] dval(input int ch, input int bt);
    return 32'hD000_0000 | (32'(ch) << 8) | 32'(bt);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_src();
    for (int i = 0; i < 4; i++) begin
      s_axis_tvalid[i] = src_on[i];
      s_axis_tdata[i*32 +: 32] =
        dval(i, (src_pkt[i] % 16) * 16 + src_beat[i]);
      s_axis_tlast[i] = (src_beat[i] == src_len[i] - 1);
    end
  endtask

  task automatic reset_src();
    for (int i = 0; i < 4; i++) begin
      src_beat[i] = 0;
      src_pkt[i]  = 0;
      src_len[i]  = 2;
    end
  endtask

  task automatic step(input logic rdy);
    @(negedge clock);
    fire = s_axis_tready & s_axis_tvalid;
    if (m_axis_tvalid === 1'b1 && m_axis_tready === 1'b1) nbeats++;
    @(posedge clock);
    #1;
    for (int i = 0; i < 4; i++) begin
      if (fire[i] === 1'b1) begin
        if (src_beat[i] == src_len[i] - 1) begin
          src_beat[i] = 0;
          src_pkt[i]++;
        end else begin
          src_beat[i]++;
        end
      end
    end
    m_axis_tready = rdy;
    drive_src();
    #1;
  endtask

  task automatic expx(input string tag, input logic b, input int ch,
                      input logic [7:0] bt, input logic last,
                      input logic flag);
    if (b) begin
      chk({tag, ".busy"}, 32'(busy), 32'd1);
      chk({tag, ".tvalid"}, 32'(m_axis_tvalid), 32'd1);
      chk({tag, ".tdest"}, 32'(m_axis_tdest), 32'(ch));
      chk({tag, ".tdata"}, m_axis_tdata, dval(ch, int'(bt)));
      chk({tag, ".tlast"}, 32'(m_axis_tlast), 32'(last));
      chk({tag, ".s_tready"}, 32'(s_axis_tready),
          m_axis_tready ? (32'd1 << ch) : 32'd0);
    end else begin
      chk({tag, ".busy"}, 32'(busy), 32'd0);
      chk({tag, ".tvalid"}, 32'(m_axis_tvalid), 32'd0);
      chk({tag, ".tdest"}, 32'(m_axis_tdest), 32'd0);
      chk({tag, ".tdata"}, m_axis_tdata, 32'd0);
      chk({tag, ".tlast"}, 32'(m_axis_tlast), 32'd0);
      chk({tag, ".s_tready"}, 32'(s_axis_tready), 32'd0);
    end
    chk({tag, ".stall"}, 32'(stall_flag), 32'(flag));
  endtask

  task automatic do_reset(input string tag);
    reset = 1'b1;
    ch_enable = '0;
    src_on = '0;
    m_axis_tready = 1'b0;
    reset_src();
    drive_src();
    step(1'b0);
    step(1'b0);
    expx(tag, 1'b0, 0, 8'h00, 1'b0, 1'b0);
  endtask

  task automatic cfg(input logic [3:0] en, input logic [3:0] on,
                     input int len);
    reset = 1'b0;
    ch_enable = en;
    src_on = on;
    for (int i = 0; i < 4; i++) src_len[i] = len;
    m_axis_tready = 1'b1;
    drive_src();
    #1;
  endtask

  initial begin
    int b0;

    // Full round robin over four channels, two-beat packets.
    do_reset("t1.rst");
    cfg(4'b1111, 4'b1111, 2);
    expx("t1.c0", 1'b0, 0, 8'h00, 1'b0, 1'b0);
    for (int k = 0; k < 14; k++) begin
      step(1'b1);
      expx($sformatf("t1.c%0d", k + 1), t1_ch[k] >= 0,
           (t1_ch[k] >= 0) ? t1_ch[k] : 0, t1_bt[k], t1_bt[k][0], 1'b0);
    end

    // Only ch2 enabled while everyone requests.
    do_reset("t2.rst");
    cfg(4'b0100, 4'b1111, 2);
    for (int k = 0; k < 5; k++) begin
      step(1'b1);
      expx($sformatf("t2.c%0d", k + 1), t2_ch[k] >= 0,
           (t2_ch[k] >= 0) ? t2_ch[k] : 0, t2_bt[k], t2_bt[k][0], 1'b0);
    end

    // Enable dropped mid-packet does not truncate.
    do_reset("t3.rst");
    cfg(4'b1111, 4'b0110, 2);
    src_len[1] = 4;
    drive_src();
    #1;
    step(1'b1);
    expx("t3.c1", 1'b1, 1, 8'h00, 1'b0, 1'b0);
    ch_enable = 4'b1101;
    for (int k = 0; k < 8; k++) begin
      step(1'b1);
      expx($sformatf("t3.c%0d", k + 2), t3_ch[k] >= 0,
           (t3_ch[k] >= 0) ? t3_ch[k] : 0, t3_bt[k], t3_last[k], 1'b0);
    end

    // Stall watchdog with a limit of eight.
    do_reset("t4.rst");
    cfg(4'b1111, 4'b0001, 2);
    for (int k = 1; k <= 10; k++) begin
      step(1'b0);
      expx($sformatf("t4.c%0d", k), 1'b1, 0, 8'h00, 1'b0, k >= 9);
    end
    step(1'b1);
    expx("t4.c11", 1'b1, 0, 8'h00, 1'b0, 1'b1);
    step(1'b1);
    expx("t4.c12", 1'b1, 0, 8'h01, 1'b1, 1'b0);

    // Reset in the middle of a ch3 packet.
    do_reset("t5.rst");
    cfg(4'b1000, 4'b1000, 4);
    step(1'b1);
    expx("t5.c1", 1'b1, 3, 8'h00, 1'b0, 1'b0);
    step(1'b1);
    expx("t5.c2", 1'b1, 3, 8'h01, 1'b0, 1'b0);
    reset = 1'b1;
    step(1'b1);
    reset_src();
    ch_enable = 4'b1111;
    src_on = 4'b1111;
    drive_src();
    #1;
    expx("t5.c3", 1'b0, 0, 8'h00, 1'b0, 1'b0);
    reset = 1'b0;
    step(1'b1);
    expx("t5.c4", 1'b1, 0, 8'h00, 1'b0, 1'b0);

    // Single-beat packets with egress ready toggling.
    do_reset("t6.rst");
    cfg(4'b0011, 4'b0011, 1);
    b0 = nbeats;
    for (int k = 0; k < 9; k++) begin
      step(k % 2 == 1);
      expx($sformatf("t6.c%0d", k + 1), t6_ch[k] >= 0,
           (t6_ch[k] >= 0) ? t6_ch[k] : 0, t6_bt[k], 1'b1, 1'b0);
    end
    step(1'b0);
    chk("t6.beats", 32'(nbeats - b0), 32'd4);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
